sprite_layer_arbiter: RTL and testbench

Shares one synchronous sprite ROM among NUM_SPRITES on-screen instances of the same 30x30 sprite. Per pixel, it picks the highest-priority instance covering (DrawX, DrawY) and generates the ROM address. It then returns the palette index, aligned with a hit flag and the instance id, to the downstream palette/compositor stage. Instance positions and enables are written by game logic through a valid/ready port into shadow registers, which are committed atomically at frame start, so a frame never shows a half-updated scene.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_hit_test.sv | 30 +++
 rtl/sprite_layer_arbiter.sv | 154 +++++++++++++++
 tb/tb_sprite_layer_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite geometry, transparency key, position record and control states
// used by the sprite mappers.
package sprite_pkg;

  localparam int         SPR_W       = 30;
  localparam int         SPR_H       = 30;
  localparam logic [4:0] TRANSPARENT = 5'd0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } sprite_pos_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    COMMIT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/sprite_hit_test.sv
// Coverage test of one sprite instance against the current pixel, also
// returning the pixel offset inside the sprite for ROM addressing.
module sprite_hit_test
  import sprite_pkg::*;
#(
  parameter int W = SPR_W,
  parameter int H = SPR_H
) (
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  sprite_pos_t pos,
  output logic        hit,
  output logic [9:0]  dx,
  output logic [9:0]  dy
);

  logic [10:0] dx_ext;
  logic [10:0] dy_ext;

  // The borrow bit marks a pixel left of / above the sprite, so a sprite near
  // the right or bottom edge is clipped instead of reappearing at column 0.
  assign dx_ext = {1'b0, DrawX} - {1'b0, pos.x};
  assign dy_ext = {1'b0, DrawY} - {1'b0, pos.y};
  assign dx     = dx_ext[9:0];
  assign dy     = dy_ext[9:0];

  assign hit = pos.en & ~dx_ext[10] & ~dy_ext[10] &
               (dx < 10'(W)) & (dy < 10'(H));

endmodule

// File: rtl/sprite_layer_arbiter.sv
// Shares one sprite ROM among several instances: per-pixel priority pick,
// ROM addressing, and frame-atomic position updates via shadow registers.
module sprite_layer_arbiter #(
  parameter int         NUM_SPRITES = 4,
  parameter int         SPR_W       = sprite_pkg::SPR_W,
  parameter int         SPR_H       = sprite_pkg::SPR_H,
  parameter logic [4:0] TRANSPARENT = sprite_pkg::TRANSPARENT,
  localparam int        IDW         = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic            vga_clk,
  input  logic            reset,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  input  logic            blank,
  input  logic            frame_start,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [IDW-1:0]  req_id,
  input  logic [9:0]      req_x,
  input  logic [9:0]      req_y,
  input  logic            req_en,
  output logic [11:0]     rom_address,
  input  logic [4:0]      rom_q,
  output logic            pix_hit,
  output logic [4:0]      pix_index,
  output logic [IDW-1:0]  pix_id
);

  import sprite_pkg::*;

  ctrl_state_t state_q, state_d;
  sprite_pos_t shadow_q [NUM_SPRITES];
  sprite_pos_t active_q [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] hit;
  logic [9:0]             dx [NUM_SPRITES];
  logic [9:0]             dy [NUM_SPRITES];

  logic                   hit_any;
  logic [IDW-1:0]         sel_id;
  logic [9:0]             dx_sel;
  logic [9:0]             dy_sel;

  logic                   hit1_q;
  logic [IDW-1:0]         sel1_q;
  logic                   blank1_q;

  logic                   pix_hit_d, pix_hit_q;
  logic [4:0]             pix_index_d, pix_index_q;
  logic [IDW-1:0]         pix_id_d, pix_id_q;

  always_ff @(posedge vga_clk) begin
    if (reset) state_q <= ACCEPT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      ACCEPT: begin
        req_ready = ~reset;
        if (frame_start) state_d = COMMIT;
      end
      COMMIT: state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) shadow_q[i] <= '0;
    end else if (req_valid && req_ready) begin
      shadow_q[req_id] <= {req_x, req_y, req_en};
    end
  end

  // The scene seen by the hit test only changes in the single COMMIT cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) active_q[i] <= '0;
    end else if (state_q == COMMIT) begin
      active_q <= shadow_q;
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_test #(
      .W (SPR_W),
      .H (SPR_H)
    ) u_hit (
      .DrawX (DrawX),
      .DrawY (DrawY),
      .pos   (active_q[g]),
      .hit   (hit[g]),
      .dx    (dx[g]),
      .dy    (dy[g])
    );
  end

  // Scan from the highest index down so the lowest hitting index is left.
  always_comb begin
    hit_any = |hit;
    sel_id  = '0;
    dx_sel  = '0;
    dy_sel  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_id = IDW'(i);
        dx_sel = dx[i];
        dy_sel = dy[i];
      end
    end
  end

  assign rom_address = reset ? 12'd0 :
                       12'(dy_sel) * 12'(SPR_W) + 12'(dx_sel);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hit1_q   <= 1'b0;
      sel1_q   <= '0;
      blank1_q <= 1'b0;
    end else begin
      hit1_q   <= hit_any;
      sel1_q   <= sel_id;
      blank1_q <= blank;
    end
  end

  // rom_q arrives alongside stage 1; a transparent texel hides everything below.
  always_comb begin
    pix_hit_d   = hit1_q & blank1_q & (rom_q != TRANSPARENT);
    pix_index_d = pix_hit_d ? rom_q  : 5'd0;
    pix_id_d    = pix_hit_d ? sel1_q : '0;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      pix_hit_q   <= 1'b0;
      pix_index_q <= '0;
      pix_id_q    <= '0;
    end else begin
      pix_hit_q   <= pix_hit_d;
      pix_index_q <= pix_index_d;
      pix_id_q    <= pix_id_d;
    end
  end

  assign pix_hit   = pix_hit_q;
  assign pix_index = pix_index_q;
  assign pix_id    = pix_id_q;

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
// Scoreboard bench for sprite_layer_arbiter: stimulus queues expected values,
// a negedge monitor compares them when the DUT presents them.
module tb_sprite_layer_arbiter;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank = 1'b0;
  logic        frame_start = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_id = '0;
  logic [9:0]  req_x = '0;
  logic [9:0]  req_y = '0;
  logic        req_en = 1'b0;
  logic [11:0] rom_address;
  logic [4:0]  rom_q = '0;
  logic        pix_hit;
  logic [4:0]  pix_index;
  logic [1:0]  pix_id;

  sprite_layer_arbiter #(.NUM_SPRITES(4)) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_id      (req_id),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_en      (req_en),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_hit     (pix_hit),
    .pix_index   (pix_index),
    .pix_id      (pix_id)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  // ROM contents: (addr % 31) + 1, except address 315 which is transparent.
  function automatic logic [4:0] romData(input logic [11:0] a);
    if (a == 12'd315) return 5'd0;
    return 5'((a % 12'd31) + 12'd1);
  endfunction

  always @(posedge vga_clk) rom_q <= romData(rom_address);

  typedef enum int {K_PIX, K_ADDR, K_READY} kind_t;
  typedef struct {
    kind_t       kind;
    int          due;
    logic [11:0] addr;
    logic        rdy;
    logic        hit;
    logic [4:0]  idx;
    logic [1:0]  id;
    string       name;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input exp_t e);
    checks++;
    case (e.kind)
      K_PIX: if (pix_hit !== e.hit || pix_index !== e.idx || pix_id !== e.id) begin
        errors++;
        $display("[TB] FAIL %s: got hit=%0b idx=%0d id=%0d, required hit=%0b idx=%0d id=%0d",
                 e.name, pix_hit, pix_index, pix_id, e.hit, e.idx, e.id);
      end
      K_ADDR: if (rom_address !== e.addr) begin
        errors++;
        $display("[TB] FAIL %s: got rom_address=%0d, required %0d", e.name, rom_address, e.addr);
      end
      default: if (req_ready !== e.rdy) begin
        errors++;
        $display("[TB] FAIL %s: got req_ready=%0b, required %0b", e.name, req_ready, e.rdy);
      end
    endcase
  endtask

  // Monitor: compares every expectation whose cycle has arrived.
  always @(negedge vga_clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        if (sb[i].due < cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL %s: overdue at cycle %0d, required at cycle %0d", sb[i].name, cyc, sb[i].due);
        end else begin
          checkOutput(sb[i]);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic expectPix(input int due, input logic h, input logic [4:0] idx,
                           input logic [1:0] id, input string name);
    exp_t e;
    e = '{kind: K_PIX, due: due, addr: '0, rdy: 1'b0, hit: h, idx: idx, id: id, name: name};
    sb.push_back(e);
  endtask

  task automatic expectAddr(input int due, input logic [11:0] a, input string name);
    exp_t e;
    e = '{kind: K_ADDR, due: due, addr: a, rdy: 1'b0, hit: 1'b0, idx: '0, id: '0, name: name};
    sb.push_back(e);
  endtask

  task automatic expectReady(input int due, input logic r, input string name);
    exp_t e;
    e = '{kind: K_READY, due: due, addr: '0, rdy: r, hit: 1'b0, idx: '0, id: '0, name: name};
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int x, input int y, input logic bl,
                               input int expAddr, input logic expHit,
                               input int expIdx, input int expId, input string name);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = bl;
    expectAddr(cyc, 12'(expAddr), {name, " addr"});
    expectPix(cyc + 2, expHit, 5'(expIdx), 2'(expId), {name, " pix"});
    step();
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      expectReady(cyc, 1'b0, "ready in reset");
      expectPix(cyc, 1'b0, 5'd0, 2'd0, "pix in reset");
      step();
    end
    reset = 1'b0;
    expectReady(cyc, 1'b1, "ready after reset");
    expectPix(cyc, 1'b0, 5'd0, 2'd0, "pix after reset 0");
    expectPix(cyc + 1, 1'b0, 5'd0, 2'd0, "pix after reset 1");
  endtask

  task automatic writeReq(input int id, input int x, input int y, input logic en);
    req_valid = 1'b1;
    req_id    = 2'(id);
    req_x     = 10'(x);
    req_y     = 10'(y);
    req_en    = en;
    expectReady(cyc, 1'b1, "write ready");
    step();
    req_valid = 1'b0;
  endtask

  task automatic frameCommit();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    expectReady(cyc, 1'b0, "commit ready");
    step();
  endtask

  task automatic writeWithFrame(input int id, input int x, input int y, input logic en);
    req_valid   = 1'b1;
    frame_start = 1'b1;
    req_id      = 2'(id);
    req_x       = 10'(x);
    req_y       = 10'(y);
    req_en      = en;
    expectReady(cyc, 1'b1, "write+frame ready");
    step();
    req_valid   = 1'b0;
    frame_start = 1'b0;
    expectReady(cyc, 1'b0, "write+frame commit ready");
    step();
  endtask

  int sweepX[3] = '{0, 100, 639};
  int sweepY[3] = '{0, 50, 479};

  initial begin
    doReset(2);

    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        applyStimulus(sweepX[i], sweepY[j], 1'b1, 0, 1'b0, 0, 0, "empty sweep");

    writeReq(0, 100, 50, 1'b1);
    frameCommit();
    applyStimulus(105, 52, 1'b1, 65, 1'b1, 4, 0, "single id0");

    writeReq(2, 110, 50, 1'b1);
    frameCommit();
    applyStimulus(115, 60, 1'b1, 315, 1'b0, 0, 0, "overlap transparent");
    applyStimulus(125, 60, 1'b1, 325, 1'b1, 16, 0, "overlap id0 wins");
    applyStimulus(135, 60, 1'b1, 325, 1'b1, 16, 2, "id2 alone");

    writeReq(1, 200, 200, 1'b1);
    applyStimulus(205, 205, 1'b1, 0, 1'b0, 0, 0, "uncommitted id1");
    frameCommit();
    applyStimulus(205, 205, 1'b1, 155, 1'b1, 1, 1, "committed id1");

    writeReq(1, 300, 300, 1'b1);
    writeReq(1, 400, 100, 1'b1);
    frameCommit();
    applyStimulus(405, 105, 1'b1, 155, 1'b1, 1, 1, "last write wins");
    applyStimulus(305, 305, 1'b1, 0, 1'b0, 0, 0, "overwritten pos");

    writeWithFrame(3, 1010, 100, 1'b1);
    applyStimulus(1015, 105, 1'b1, 155, 1'b1, 1, 3, "write with frame_start");
    applyStimulus(5, 105, 1'b1, 0, 1'b0, 0, 0, "no edge wrap");

    applyStimulus(105, 52, 1'b0, 65, 1'b0, 0, 0, "blanked pixel");

    step();
    step();
    step();
    writeReq(0, 300, 300, 1'b1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    doReset(2);
    applyStimulus(105, 52, 1'b1, 0, 1'b0, 0, 0, "reset in commit id0");
    applyStimulus(1015, 105, 1'b1, 0, 1'b0, 0, 0, "reset in commit id3");
    frameCommit();
    applyStimulus(305, 305, 1'b1, 0, 1'b0, 0, 0, "discarded shadow write");

    for (int i = 0; i < 6; i++) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
